// File: rtl/input_debouncer.sv
// Per-bit synchronizer and counter-based debouncer feeding the 4-bit D register.
// Emits registered rise/fall pulses, an aggregate change strobe and a stable flag.
module input_debouncer #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             en,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             stable
);

  localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  sync_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_d;
  logic [WIDTH-1:0]                  d_next;
  logic [WIDTH-1:0]                  rise_d;
  logic [WIDTH-1:0]                  fall_d;
  logic [WIDTH-1:0]                  busy;

  // Synchronizer runs regardless of en so the sample is fresh when counting resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    d_next = d_out;
    rise_d = '0;
    fall_d = '0;
    busy   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      busy[i] = (cnt_q[i] != '0);
      if (en) begin
        if (sync_q[i] == d_out[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == TERM) begin
          cnt_d[i]  = '0;
          d_next[i] = sync_q[i];
          rise_d[i] = sync_q[i];
          fall_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      d_out   <= RESET_VAL;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      d_out   <= d_next;
      rise    <= rise_d;
      fall    <= fall_d;
      changed <= |(rise_d | fall_d);
    end
  end

  assign stable = ~|busy;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: vector table, directed corner sequences and a
// randomized run, all checked against a run-length reference model.
module tb_input_debouncer;

  localparam int         W  = 4;
  localparam int         SS = 2;
  localparam int         DC = 4;
  localparam logic [3:0] RV = 4'h0;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b1;
  logic [3:0] raw_in = 4'hF;
  logic [3:0] d_out, rise, fall;
  logic       changed, stable;

  int checks   = 0;
  int failures = 0;

  input_debouncer #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en),
    .d_out(d_out), .rise(rise), .fall(fall), .changed(changed), .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: hist is a delay line of raw samples (hist[SS-1] is the value
  // the debouncer sees now); run counts consecutive enabled samples differing from d.
  typedef struct packed {
    logic [3:0]             d;
    logic [3:0]             rise;
    logic [3:0]             fall;
    logic                   ch;
    logic [W-1:0][7:0]      run;
    logic [SS-1:0][3:0]     hist;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t s;
    s.d    = RV;
    s.rise = '0;
    s.fall = '0;
    s.ch   = 1'b0;
    s.run  = '0;
    s.hist = {SS{RV}};
    return s;
  endfunction

  function automatic mstate_t mstep(mstate_t s, logic [3:0] raw, logic e);
    mstate_t    n    = s;
    logic [3:0] samp = s.hist[SS-1];
    n.hist = {s.hist[SS-2:0], raw};
    n.rise = '0;
    n.fall = '0;
    if (e) begin
      for (int i = 0; i < W; i++) begin
        n.run[i] = (samp[i] != s.d[i]) ? s.run[i] + 8'd1 : 8'd0;
        if (int'(n.run[i]) == DC) begin
          n.run[i] = 8'd0;
          n.d[i]   = samp[i];
          if (samp[i]) n.rise[i] = 1'b1;
          else         n.fall[i] = 1'b1;
        end
      end
    end
    n.ch = |(n.rise | n.fall);
    return n;
  endfunction

  mstate_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mreset();
    else        m <= mstep(m, raw_in, en);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_d_out",   {28'd0, d_out}, {28'd0, m.d});
      chk("model_rise",    {28'd0, rise},  {28'd0, m.rise});
      chk("model_fall",    {28'd0, fall},  {28'd0, m.fall});
      chk("model_changed", {31'd0, changed}, {31'd0, m.ch});
      chk("model_stable",  {31'd0, stable},  {31'd0, (m.run == '0)});
    end
  end

  typedef struct {
    logic [3:0] raw;
    logic       en;
    logic [3:0] d;
    logic [3:0] ri;
    logic [3:0] fa;
    logic       ch;
    logic       st;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int         rises;
    int         at_edge;
    logic       saw_unstable;
    logic [3:0] rise_acc;

    // Reset-then-step: d_out updates on edge 6 after release.
    tbl[0] = '{4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    tbl[1] = '{4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    tbl[2] = '{4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[3] = '{4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[4] = '{4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[5] = '{4'hF, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1};
    tbl[6] = '{4'hF, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};

    #1;
    chk("reset_d_out",   {28'd0, d_out}, 32'h0);
    chk("reset_rise",    {28'd0, rise},  32'h0);
    chk("reset_fall",    {28'd0, fall},  32'h0);
    chk("reset_changed", {31'd0, changed}, 32'h0);
    chk("reset_stable",  {31'd0, stable},  32'h1);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      raw_in = tbl[k].raw;
      en     = tbl[k].en;
      @(negedge clk);
      chk($sformatf("step%0d_d_out", k + 1),   {28'd0, d_out}, {28'd0, tbl[k].d});
      chk($sformatf("step%0d_rise", k + 1),    {28'd0, rise},  {28'd0, tbl[k].ri});
      chk($sformatf("step%0d_fall", k + 1),    {28'd0, fall},  {28'd0, tbl[k].fa});
      chk($sformatf("step%0d_changed", k + 1), {31'd0, changed}, {31'd0, tbl[k].ch});
      chk($sformatf("step%0d_stable", k + 1),  {31'd0, stable},  {31'd0, tbl[k].st});
    end

    // Glitch of 3 samples on bit 0 is rejected.
    raw_in = 4'h0;
    repeat (8) @(negedge clk);
    saw_unstable = 1'b0;
    rise_acc     = '0;
    for (int k = 1; k <= 12; k++) begin
      raw_in = (k <= 3) ? 4'h1 : 4'h0;
      @(negedge clk);
      if (!stable) saw_unstable = 1'b1;
      rise_acc |= rise;
      chk("glitch_d_out", {28'd0, d_out}, 32'h0);
    end
    chk("glitch_rise_seen", {28'd0, rise_acc}, 32'h0);
    chk("glitch_unstable",  {31'd0, saw_unstable}, 32'h1);
    chk("glitch_settled",   {31'd0, stable}, 32'h1);

    // Independent bits: bit1 rises at t, bit2 falls at t+20.
    raw_in = 4'h4;
    repeat (8) @(negedge clk);
    chk("indep_start", {28'd0, d_out}, 32'h4);
    for (int k = 1; k <= 10; k++) begin
      raw_in = (k >= 3) ? 4'h2 : 4'h6;
      @(negedge clk);
      chk("indep_d_out", {28'd0, d_out}, (k < 6) ? 32'h4 : (k < 8) ? 32'h6 : 32'h2);
      chk("indep_rise",  {28'd0, rise},  (k == 6) ? 32'h2 : 32'h0);
      chk("indep_fall",  {28'd0, fall},  (k == 8) ? 32'h4 : 32'h0);
    end

    // Enable freeze: en low for edges 5..9 holds the count at 2.
    for (int k = 1; k <= 13; k++) begin
      raw_in = 4'hA;
      en     = (k >= 5 && k <= 9) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("freeze_d_out", {28'd0, d_out}, (k <= 10) ? 32'h2 : 32'hA);
      chk("freeze_rise",  {28'd0, rise},  (k == 11) ? 32'h8 : 32'h0);
      if (k >= 4 && k <= 10) chk("freeze_stable", {31'd0, stable}, 32'h0);
    end
    en = 1'b1;

    // Async reset in the middle of a count.
    raw_in = 4'hF;
    repeat (8) @(negedge clk);
    chk("areset_pre_d_out", {28'd0, d_out}, 32'hF);
    raw_in = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("areset_pre_stable", {31'd0, stable}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_d_out",   {28'd0, d_out}, 32'h0);
    chk("areset_fall",    {28'd0, fall},  32'h0);
    chk("areset_changed", {31'd0, changed}, 32'h0);
    chk("areset_stable",  {31'd0, stable},  32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Bounce on bit 0 then hold 1: one rise, edge 6 after the final transition.
    repeat (4) @(negedge clk);
    rises = 0;
    for (int k = 1; k <= 10; k++) begin
      raw_in[0] = ~raw_in[0];
      @(negedge clk);
      if (rise[0]) rises++;
    end
    raw_in  = 4'h1;
    at_edge = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rise[0]) begin
        rises++;
        at_edge = k;
      end
    end
    chk("bounce_rise_count", rises, 32'd1);
    chk("bounce_rise_edge",  at_edge, 32'd6);

    // Randomized traffic: sparse per-bit flips, occasional enable drops.
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(7) == 0) raw_in[b] = ~raw_in[b];
      en = ($urandom_range(15) != 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the 4-bit D register.
- Takes raw asynchronous inputs (switches/buttons) and synchronizes each bit through a flop chain.
- Debounces each bit with its own counter and presents a clean, registered WIDTH-bit value on d_out, which drives the register's d input directly.
- Also emits per-bit rise/fall pulses and an aggregate change strobe for downstream control logic.

Parameters:
- WIDTH, 4, number of independent input bits.
- SYNC_STAGES, 2, synchronizer flops per bit (legal ≥2).
- DEBOUNCE_CYCLES, 4, consecutive differing synchronized samples required before d_out updates (legal ≥1).
- RESET_VAL, 4'h0, reset value of d_out and of every synchronizer flop (WIDTH bits).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- raw_in, input, WIDTH, raw asynchronous inputs.
- en, input, 1, debounce enable; 0 freezes counters and outputs.
- d_out, output, WIDTH, debounced registered value (feeds D register d).
- rise, output, WIDTH, 1-cycle pulse per bit on 0→1 update of d_out.
- fall, output, WIDTH, 1-cycle pulse per bit on 1→0 update of d_out.
- changed, output, 1, registered OR of all rise|fall bits.
- stable, output, 1, 1 when no bit has a pending (nonzero) debounce count.

Behaviour:
- Reset (rst_n=0, async, no clock needed):
  - sync chain = RESET_VAL, d_out = RESET_VAL, counters = 0.
  - rise = fall = 0, changed = 0, stable = 1.
  - Values hold while rst_n=0.
- Synchronizer:
  - Per bit, SYNC_STAGES flops; always clocked, independent of en.
  - sync_q is the last stage.
- Per-bit debounce, evaluated each rising edge with en=1:
  - sync_q == d_out[i]: cnt[i] ← 0.
  - sync_q != d_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] ← cnt[i]+1.
  - sync_q != d_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: d_out[i] ← sync_q, cnt[i] ← 0, and rise[i] or fall[i] ← 1 for exactly this cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). No wrap is possible because the count clears at terminal.
- Latency: d_out changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after raw_in changes, counting the first edge that samples the new value as edge 1. Defaults: edge 6.
- Glitch rejection: a value held for fewer than DEBOUNCE_CYCLES consecutive sync samples clears its counter; no d_out change and no pulse.
- Bits are fully independent. Multiple bits may update on the same edge; rise and fall may both be nonzero in one cycle on different bits.
- Pulses: rise, fall and changed are registered and default to 0 every cycle unless set by an update.
- en=0:
  - cnt and d_out hold; rise = fall = changed = 0 on that edge.
  - Sync chain keeps running.
  - On return to en=1, counting resumes from the held cnt.
- stable: combinational NOR of all cnt[i] != 0.
- Reset mid-count: all counts are lost immediately; d_out returns to RESET_VAL with no pulse.
- First edge after rst_n deassertion behaves as a normal cycle. No spurious pulses occur because the sync chain and d_out share RESET_VAL.
- DEBOUNCE_CYCLES=1: d_out follows sync_q with a 1-cycle register delay.

Test Plan:
- Clock period 10; defaults throughout.
- Reset then step: rst_n=0 with raw_in=4'hF, release, hold 4'hF → d_out=4'h0 until edge 6 after release. Then d_out=4'hF, rise=4'hF and changed=1 for one cycle, fall=0, and stable returns to 1.
- Glitch: d_out=0, raw_in[0]=1 for 3 cycles then 0 → d_out stays 4'h0, rise never asserts, stable=0 during the count then 1.
- Independent bits: from d_out=4'h4, raw_in[1]↑ at t, raw_in[2]↓ at t+20 → rise=4'h2 at edge 6 after t, fall=4'h4 two cycles later, d_out 4'h4→4'h6→4'h2.
- Enable freeze: raw_in[3]↑, en=0 after 4 edges for 5 cycles, then en=1 → no change while en=0 (cnt held at 2); d_out[3] rises 2 edges after en re-asserts.
- Async reset mid-count: d_out=4'hF, raw_in=4'h0, assert rst_n=0 between edges at count 3 → d_out=4'h0 immediately with no clock edge, no fall pulse, stable=1.
- Bounce: raw_in[0] toggles every cycle for 10 cycles then holds 1 → exactly one rise[0] pulse, at edge 6 after the final transition.
